miriscv_mem_arbiter: RTL and testbench

MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

---
 rtl/miriscv_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// miriscv_mem_arbiter
//
// Two-master arbiter in front of a single-port data RAM. Master 0 is the core
// LSU and master 1 is the DMA/debug port. At most one transaction is in flight.
// A grant is issued in an IDLE cycle, and the response comes back in the
// following RESP cycle, so throughput is one transaction every two cycles.
//
// Handshake (both masters):
//   mN_req_i is held high, with we/be/addr/wdata stable, until mN_gnt_o is seen
//   high in the same cycle. The request is accepted on that clock edge.
//   Exactly one cycle later mN_rvalid_o pulses for one cycle, together with
//   mN_rdata_o and mN_err_o. If req is still high after rvalid, that is a new
//   request that competes in the next IDLE cycle.
//
// Parameters:
//   RAM_SIZE          RAM size in bytes. Byte addresses >= RAM_SIZE never
//                     reach the RAM and complete with an error response.
//
// Configuration macro:
//   MIRISCV_ARB_ROUND_ROBIN_EN
//     defined   - when both masters request, grant the one not granted last.
//     undefined - fixed priority: master 0 wins simultaneous requests.
//
// Ports:
//   clk_i, rst_n_i            clock and synchronous active-low reset
//   mN_req_i/we_i/be_i/       master N request, write enable, byte enables,
//   addr_i/wdata_i            byte address and write data
//   mN_gnt_o                  master N request accepted this cycle
//   mN_rvalid_o/rdata_o/err_o master N response pulse, read data, error flag
//   mem_req_o/we_o/be_o/      RAM data-port controls
//   addr_o/wdata_o
//   mem_rdata_i               RAM read data, valid one cycle after mem_req_o
//   dbg_state_o               FSM state (0 = IDLE, 1 = RESP)
//   dbg_last_grant_o          master granted most recently
// -----------------------------------------------------------------------------
module miriscv_mem_arbiter #(
    parameter int unsigned RAM_SIZE = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,

    output logic        dbg_state_o,
    output logic        dbg_last_grant_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;  // master granted most recently
    logic        sel_q;         // master that owns the in-flight transaction
    logic        we_q;          // in-flight transaction is a write
    logic        err_q;         // in-flight transaction is out of range

    logic        any_req;
    logic        sel;           // 0 = master 0, 1 = master 1
    logic        grant;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic [31:0] resp_rdata;

    // ------------------------------------------------------------------
    // Master selection. Only meaningful when any_req is high.
    // ------------------------------------------------------------------
    always_comb begin
        any_req = m0_req_i | m1_req_i;
`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
        if (m0_req_i && m1_req_i) begin
            sel = ~last_grant_q;
        end else begin
            sel = ~m0_req_i;
        end
`else
        sel = ~m0_req_i;
`endif
    end

    assign sel_we    = sel ? m1_we_i    : m0_we_i;
    assign sel_be    = sel ? m1_be_i    : m0_be_i;
    assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
    assign in_range  = (sel_addr < 32'(RAM_SIZE));

    // Writes and out-of-range accesses return zero data.
    assign resp_rdata = (err_q || we_q) ? 32'h0 : mem_rdata_i;

    // ------------------------------------------------------------------
    // Next state and outputs. Everything is forced to zero while reset is
    // asserted so a transaction caught by reset never produces a response.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = 32'h0;
        m1_rdata_o  = 32'h0;
        m0_err_o    = 1'b0;
        m1_err_o    = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;

        if (rst_n_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant       = 1'b1;
                        state_d     = ST_RESP;
                        m0_gnt_o    = ~sel;
                        m1_gnt_o    = sel;
                        mem_req_o   = in_range;
                        mem_we_o    = sel_we;
                        mem_be_o    = sel_be;
                        mem_addr_o  = sel_addr;
                        mem_wdata_o = sel_wdata;
                    end
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                    if (sel_q) begin
                        m1_rvalid_o = 1'b1;
                        m1_rdata_o  = resp_rdata;
                        m1_err_o    = err_q;
                    end else begin
                        m0_rvalid_o = 1'b1;
                        m0_rdata_o  = resp_rdata;
                        m0_err_o    = err_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register and per-transaction context.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;  // so master 0 wins the first contention
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_grant_q <= sel;
                sel_q        <= sel;
                we_q         <= sel_we;
                err_q        <= ~in_range;
            end
        end
    end

    assign dbg_state_o      = state_q;
    assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_miriscv_mem_arbiter
//
// Bench for miriscv_mem_arbiter. A simple RAM responder sits on the memory
// port. A transaction-level model (busy flag, pending transaction record,
// last-granted master and a shadow copy of the RAM contents) predicts every
// output at each falling edge, and directed sequences add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_miriscv_mem_arbiter;

    localparam int unsigned RAM_SIZE = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_be = 4'h0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_be = 4'h0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        dbg_state, dbg_last_grant;

    miriscv_mem_arbiter #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .dbg_state_o(dbg_state), .dbg_last_grant_o(dbg_last_grant)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM responder ----------------
    logic [31:0] ram [64];
    logic [31:0] mdl_mem [64];

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdata = ram[mem_addr[7:2]];
            end
        end
    end

    // ---------------- transaction-level model ----------------
    bit          cmp_en  = 1'b0;
    bit          m_busy  = 1'b0;   // a response is owed this cycle
    bit          m_last  = 1'b1;   // master granted most recently
    bit          m_pm    = 1'b0;   // owner of the pending response
    bit          m_pwe   = 1'b0;
    bit          m_perr  = 1'b0;
    logic [31:0] m_paddr = 32'h0;

    function automatic bit mdl_pick();
        if (m0_req && m1_req) begin
`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
            return !m_last;
`else
            return 1'b0;
`endif
        end
        return m0_req ? 1'b0 : 1'b1;
    endfunction

    always @(posedge clk) begin
        bit          p;
        logic [31:0] a, wd;
        logic [3:0]  be;
        bit          we;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (m0_req || m1_req) begin
            p  = mdl_pick();
            a  = p ? m1_addr  : m0_addr;
            wd = p ? m1_wdata : m0_wdata;
            be = p ? m1_be    : m0_be;
            we = p ? m1_we    : m0_we;
            m_busy  = 1'b1;
            m_pm    = p;
            m_pwe   = we;
            m_perr  = !(a < RAM_SIZE);
            m_paddr = a;
            m_last  = p;
            if (we && (a < RAM_SIZE))
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic        e_g0, e_g1, e_v0, e_v1, e_e0, e_e1, e_mreq, e_mwe;
        logic [31:0] e_r0, e_r1, e_maddr, e_mwd, rv;
        logic [3:0]  e_mbe;
        bit          p;
        if (cmp_en) begin
            e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0; e_e0 = 0; e_e1 = 0;
            e_r0 = 0; e_r1 = 0; e_mreq = 0; e_mwe = 0; e_mbe = 0;
            e_maddr = 0; e_mwd = 0;
            if (rst_n) begin
                if (m_busy) begin
                    rv = (m_perr || m_pwe) ? 32'h0 : mdl_mem[m_paddr[7:2]];
                    if (m_pm) begin e_v1 = 1; e_r1 = rv; e_e1 = m_perr; end
                    else      begin e_v0 = 1; e_r0 = rv; e_e0 = m_perr; end
                end else if (m0_req || m1_req) begin
                    p = mdl_pick();
                    e_g0    = !p;
                    e_g1    = p;
                    e_maddr = p ? m1_addr  : m0_addr;
                    e_mwd   = p ? m1_wdata : m0_wdata;
                    e_mbe   = p ? m1_be    : m0_be;
                    e_mwe   = p ? m1_we    : m0_we;
                    e_mreq  = (e_maddr < RAM_SIZE);
                end
            end
            chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
            chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
            chk("m0_rvalid", 32'(m0_rvalid), 32'(e_v0));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(e_v1));
            chk("m0_rdata", m0_rdata, e_r0);
            chk("m1_rdata", m1_rdata, e_r1);
            chk("m0_err", 32'(m0_err), 32'(e_e0));
            chk("m1_err", 32'(m1_err), 32'(e_e1));
            chk("mem_req", 32'(mem_req), 32'(e_mreq));
            chk("mem_we", 32'(mem_we), 32'(e_mwe));
            chk("mem_be", 32'(mem_be), 32'(e_mbe));
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_wdata", mem_wdata, e_mwd);
            chk("dbg_state", 32'(dbg_state), 32'(m_busy));
            chk("dbg_last_grant", 32'(dbg_last_grant), 32'(m_last));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input bit m, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit req);
        if (m) begin
            m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata; m1_req = req;
        end else begin
            m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata; m0_req = req;
        end
    endtask

    // One complete transaction from master m; returns the response fields.
    task automatic txn(input bit m, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er);
        bit got = 1'b0;
        rd = 32'h0;
        er = 1'b0;
        tick();
        set_m(m, we, be, addr, wdata, 1'b1);
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (m ? m1_gnt : m0_gnt) got = 1'b1;
            else tick();
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL txn_timeout: master %0d addr 0x%08h no grant within 8 cycles", m, addr);
            if (m) m1_req = 1'b0; else m0_req = 1'b0;
            return;
        end
        tick();
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
        @(negedge clk);
        chk("txn_rvalid", 32'(m ? m1_rvalid : m0_rvalid), 32'h1);
        rd = m ? m1_rdata : m0_rdata;
        er = m ? m1_err : m0_err;
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] rd;
    logic        er;
    int          gq [$];
    int          exp_order [4];

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'h0;
            mdl_mem[i] = 32'h0;
        end
        ram[4]  = 32'hDEADBEEF;  mdl_mem[4]  = 32'hDEADBEEF;   // byte 0x10
        ram[63] = 32'h5A5A5A5A;  mdl_mem[63] = 32'h5A5A5A5A;   // byte 0xFC

        // Reset
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'h0);
        chk("rst_last_grant", 32'(dbg_last_grant), 32'h1);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        tick();
        rst_n = 1'b1;

        // Single read of 0x10
        tick();
        set_m(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
        @(negedge clk);
        chk("rd_gnt", 32'(m0_gnt), 32'h1);
        chk("rd_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rd_mem_req", 32'(mem_req), 32'h1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("rd_rvalid", 32'(m0_rvalid), 32'h1);
        chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(m0_err), 32'h0);

        // Write then read from master 1
        txn(1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, rd, er);
        chk("wr_err", 32'(er), 32'h0);
        chk("wr_rdata", rd, 32'h0);
        txn(1, 1'b0, 4'hF, 32'h20, 32'h0, rd, er);
        chk("wr_rd_back", rd, 32'hCAFEF00D);

        // Partial byte-enable write
        txn(0, 1'b1, 4'h3, 32'h24, 32'h11223344, rd, er);
        txn(0, 1'b0, 4'hF, 32'h24, 32'h0, rd, er);
        chk("be_rd_back", rd, 32'h00003344);

        // Out of range read at exactly RAM_SIZE
        tick();
        set_m(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1);
        @(negedge clk);
        chk("oor_gnt", 32'(m0_gnt), 32'h1);
        chk("oor_mem_req", 32'(mem_req), 32'h0);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("oor_rvalid", 32'(m0_rvalid), 32'h1);
        chk("oor_err", 32'(m0_err), 32'h1);
        chk("oor_rdata", m0_rdata, 32'h0);

        // Last in-range word, and an out-of-range write
        txn(1, 1'b0, 4'hF, 32'hFC, 32'h0, rd, er);
        chk("top_word_rdata", rd, 32'h5A5A5A5A);
        chk("top_word_err", 32'(er), 32'h0);
        txn(1, 1'b1, 4'hF, 32'h200, 32'h12345678, rd, er);
        chk("oor_wr_err", 32'(er), 32'h1);

        // Back-to-back from master 0
        tick();
        set_m(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("b2b_gnt", 32'(m0_gnt), 32'((i % 2) == 0));
            chk("b2b_rvalid", 32'(m0_rvalid), 32'((i % 2) == 1));
            tick();
        end
        m0_req = 1'b0;

        // Contention straight after reset
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_m(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
        set_m(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0_gnt) gq.push_back(0);
            if (m1_gnt) gq.push_back(1);
            tick();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        chk("cont_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("cont_order", (i < gq.size()) ? 32'(gq[i]) : 32'hFFFFFFFF, 32'(exp_order[i]));

        // Reset during the response cycle
        tick();
        set_m(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
        @(negedge clk);
        chk("mid_rst_gnt", 32'(m0_gnt), 32'h1);
        tick();
        rst_n = 1'b0;
        m0_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(m0_rvalid), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", 32'(dbg_state), 32'h0);
        chk("mid_rst_rvalid_after", 32'(m0_rvalid), 32'h0);
        chk("mid_rst_rdata_after", m0_rdata, 32'h0);
        chk("mid_rst_mem_req", 32'(mem_req), 32'h0);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
